// File: rtl/con_bus_arbiter_if.sv
// con_bus_arbiter_if: request/grant and beat handshake bundle between the arbiter and its bus partner
interface con_bus_arbiter_if;
  logic       req_k;
  logic       req_i;
  logic       req_o;
  logic       gnt_k;
  logic       gnt_i;
  logic       gnt_o;
  logic       con_valid;
  logic       con_ready;
  logic       beat;
  logic [3:0] beat_idx;
  logic       burst_done;
  logic       driving_cons;
  logic       busy;
  modport master (
    output req_k, req_i, req_o, con_valid,
    input  gnt_k, gnt_i, gnt_o, con_ready, beat, beat_idx, burst_done, driving_cons, busy
  );
  modport slave (
    input  req_k, req_i, req_o, con_valid,
    output gnt_k, gnt_i, gnt_o, con_ready, beat, beat_idx, burst_done, driving_cons, busy
  );
endinterface

// File: rtl/con_bus_arbiter.sv
// con_bus_arbiter: three-way burst arbiter for the shared con bus with output priority and K/I round-robin
module con_bus_arbiter #(
  parameter int unsigned K_BURST = 12,
  parameter int unsigned I_BURST = 4,
  parameter int unsigned O_BURST = 3
) (
  input logic          clk,
  input logic          rst_in,
  con_bus_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, OWN_K, OWN_I, OWN_O, TURN} state_t;
  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d, blen;
  logic       last_ki_q, last_ki_d, own, xfer, last;
  // beat qualification and final-beat detection for the burst owned in the current state
  always_comb begin
    own  = state_q inside {OWN_K, OWN_I, OWN_O};
    xfer = own && bus.con_valid;
    blen = state_q == OWN_K ? 4'(K_BURST) : state_q == OWN_I ? 4'(I_BURST) : 4'(O_BURST);
    last = xfer && idx_q == blen - 4'd1;
  end
  // state, beat counter and round-robin flag; reset favours K on the first K/I contest
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      last_ki_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_ki_q <= last_ki_d;
    end
  end
  // next state: arbitrate only in IDLE, run bursts to completion, one TURN cycle after an output burst
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = bus.req_o ? OWN_O :
                              (bus.req_k && (last_ki_q || !bus.req_i)) ? OWN_K :
                              bus.req_i ? OWN_I : IDLE;
      OWN_K, OWN_I: state_d = last ? IDLE : state_q;
      OWN_O:        state_d = last ? TURN : OWN_O;
      default:      state_d = IDLE;
    endcase
    idx_d     = last ? 4'd0 : xfer ? idx_q + 4'd1 : idx_q;
    last_ki_d = (last && state_q == OWN_K) ? 1'b0 : (last && state_q == OWN_I) ? 1'b1 : last_ki_q;
  end
  // outputs decoded from the state; beat and burst_done follow con_valid in the same cycle
  always_comb begin
    bus.gnt_k        = state_q == OWN_K;
    bus.gnt_i        = state_q == OWN_I;
    bus.gnt_o        = state_q == OWN_O;
    bus.con_ready    = own;
    bus.beat         = xfer;
    bus.beat_idx     = idx_q;
    bus.burst_done   = last;
    bus.driving_cons = state_q == OWN_O;
    bus.busy         = state_q != IDLE;
  end
endmodule
